// File: rtl/rvecc_scrubber.sv
// Background SEC-DED scrubber: periodically reads each SRAM word through the decoder,
// writes back single-bit corrections and logs/signals double-bit errors.
module rvecc_scrubber #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned INTERVAL = 256
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          scrub_en,
  output logic          scrub_req,
  output logic          scrub_wr,
  output logic [AW-1:0] scrub_addr,
  output logic [31:0]   scrub_wdata,
  output logic [6:0]    scrub_wecc,
  input  logic          scrub_gnt,
  output logic          dec_en,
  input  logic [31:0]   dec_dout,
  input  logic [6:0]    dec_ecc_out,
  input  logic          dec_single,
  input  logic          dec_double,
  input  logic          func_wr_vld,
  input  logic [AW-1:0] func_wr_addr,
  output logic [15:0]   sec_cnt,
  output logic [15:0]   ded_cnt,
  output logic [AW-1:0] last_err_addr,
  output logic          ded_pulse,
  output logic          pass_done,
  output logic          scrub_busy
);

  localparam int unsigned   TW     = $clog2(INTERVAL + 1);
  localparam logic [TW-1:0] RELOAD = TW'(INTERVAL);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          hazard;
  logic          last_word;
  logic          word_done;

  always_comb begin
    scrub_req = (state == RD_REQ) || (state == WR_REQ);
    scrub_wr  = (state == WR_REQ);
    dec_en    = (state == RD_WAIT);
    hazard    = func_wr_vld && (func_wr_addr == scrub_addr);
    last_word = (scrub_addr == AW'(DEPTH - 1));
    // A word is finished when no writeback is needed, the writeback is granted,
    // or a functional write to the same address makes the correction stale.
    word_done = ((state == RD_WAIT) && (dec_double || !dec_single || hazard)) ||
                ((state == WR_REQ) && (scrub_gnt || hazard));
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= IDLE;
      timer         <= RELOAD;
      scrub_addr    <= '0;
      scrub_wdata   <= '0;
      scrub_wecc    <= '0;
      sec_cnt       <= '0;
      ded_cnt       <= '0;
      last_err_addr <= '0;
      ded_pulse     <= 1'b0;
      pass_done     <= 1'b0;
      scrub_busy    <= 1'b0;
    end else begin
      ded_pulse <= 1'b0;
      pass_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (scrub_en) begin
            timer <= timer - 1'b1;
            if (timer <= TW'(1)) begin
              state      <= RD_REQ;
              scrub_busy <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (scrub_gnt) begin
            state <= RD_WAIT;
          end else if (!scrub_en) begin
            state      <= IDLE;
            scrub_busy <= 1'b0;
            timer      <= RELOAD;
          end
        end
        RD_WAIT: begin
          if (dec_double) begin
            if (ded_cnt != '1) ded_cnt <= ded_cnt + 1'b1;
            last_err_addr <= scrub_addr;
            ded_pulse     <= 1'b1;
          end else if (dec_single) begin
            if (sec_cnt != '1) sec_cnt <= sec_cnt + 1'b1;
            last_err_addr <= scrub_addr;
            scrub_wdata   <= dec_dout;
            scrub_wecc    <= dec_ecc_out;
            if (!hazard) state <= WR_REQ;
          end
        end
        WR_REQ: begin
        end
      endcase
      // Overrides the per-state transition: every finished word returns to IDLE.
      if (word_done) begin
        state      <= IDLE;
        scrub_busy <= 1'b0;
        timer      <= RELOAD;
        scrub_addr <= scrub_addr + 1'b1;
        pass_done  <= last_word;
      end
    end
  end

endmodule

// File: tb/tb_rvecc_scrubber.sv
// Bench for rvecc_scrubber: directed scenarios plus random stimulus, with every cycle
// checked against a transaction-level model of the scrub walk.
module tb_rvecc_scrubber;

  localparam int DEPTH    = 4;
  localparam int AW       = 2;
  localparam int INTERVAL = 4;

  localparam int P_IDLE = 0;
  localparam int P_RR   = 1;
  localparam int P_RW   = 2;
  localparam int P_WR   = 3;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          scrub_en;
  logic          scrub_req;
  logic          scrub_wr;
  logic [AW-1:0] scrub_addr;
  logic [31:0]   scrub_wdata;
  logic [6:0]    scrub_wecc;
  logic          scrub_gnt;
  logic          dec_en;
  logic [31:0]   dec_dout;
  logic [6:0]    dec_ecc_out;
  logic          dec_single;
  logic          dec_double;
  logic          func_wr_vld;
  logic [AW-1:0] func_wr_addr;
  logic [15:0]   sec_cnt;
  logic [15:0]   ded_cnt;
  logic [AW-1:0] last_err_addr;
  logic          ded_pulse;
  logic          pass_done;
  logic          scrub_busy;

  rvecc_scrubber #(.DEPTH(DEPTH), .AW(AW), .INTERVAL(INTERVAL)) dut (
    .clk(clk), .rst_l(rst_l), .scrub_en(scrub_en),
    .scrub_req(scrub_req), .scrub_wr(scrub_wr), .scrub_addr(scrub_addr),
    .scrub_wdata(scrub_wdata), .scrub_wecc(scrub_wecc), .scrub_gnt(scrub_gnt),
    .dec_en(dec_en), .dec_dout(dec_dout), .dec_ecc_out(dec_ecc_out),
    .dec_single(dec_single), .dec_double(dec_double),
    .func_wr_vld(func_wr_vld), .func_wr_addr(func_wr_addr),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .last_err_addr(last_err_addr),
    .ded_pulse(ded_pulse), .pass_done(pass_done), .scrub_busy(scrub_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int t     = 0;

  // model of the scrub walk
  int          m_ph, m_left, m_addr, m_sec, m_ded, m_last, m_nsingle;
  logic [31:0] m_wd;
  logic [6:0]  m_we;
  bit          m_dp, m_pd;

  // injection policy for directed scenarios (-1 = none, -2 = every address)
  int          inj_s = -1, inj_d = -1, hz_addr = -1;
  bit          inj_fixed = 1'b0;
  logic [31:0] inj_dout = '0;
  logic [6:0]  inj_ecc = '0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    logic [6:0]  ecc;
  } wr_t;
  wr_t writes[$];
  int  reads[$];
  int  rd_cyc[$];
  int  n_dp = 0, n_pd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @t=%0d: got %0h, want %0h", nm, t, act, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_left = INTERVAL; m_addr = 0; m_sec = 0; m_ded = 0;
    m_last = 0; m_wd = '0; m_we = '0; m_dp = 1'b0; m_pd = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit gnt, input bit sng, input bit dbl,
                            input logic [31:0] dout, input logic [6:0] ecc,
                            input bit fv, input int fa);
    bit hz;
    bit done;
    if (!rst_l) begin
      model_reset();
      return;
    end
    hz   = fv && (fa == m_addr);
    done = 1'b0;
    m_dp = 1'b0;
    m_pd = 1'b0;
    case (m_ph)
      P_IDLE: if (en) begin
        m_left--;
        if (m_left == 0) m_ph = P_RR;
      end
      P_RR: if (gnt) m_ph = P_RW;
            else if (!en) begin m_ph = P_IDLE; m_left = INTERVAL; end
      P_RW: begin
        if (dbl) begin
          m_ded = sat16(m_ded); m_last = m_addr; m_dp = 1'b1; done = 1'b1;
        end else if (sng) begin
          m_sec = sat16(m_sec); m_last = m_addr; m_wd = dout; m_we = ecc;
          m_nsingle++;
          if (hz) done = 1'b1; else m_ph = P_WR;
        end else begin
          done = 1'b1;
        end
      end
      default: if (gnt || hz) done = 1'b1;
    endcase
    if (done) begin
      m_pd   = (m_addr == DEPTH - 1);
      m_addr = (m_addr + 1) % DEPTH;
      m_ph   = P_IDLE;
      m_left = INTERVAL;
    end
  endtask

  task automatic compare_all();
    chk("scrub_req", 32'(scrub_req), 32'((m_ph == P_RR) || (m_ph == P_WR)));
    chk("scrub_wr", 32'(scrub_wr), 32'(m_ph == P_WR));
    chk("dec_en", 32'(dec_en), 32'(m_ph == P_RW));
    chk("scrub_busy", 32'(scrub_busy), 32'(m_ph != P_IDLE));
    chk("scrub_addr", 32'(scrub_addr), m_addr);
    chk("scrub_wdata", scrub_wdata, m_wd);
    chk("scrub_wecc", 32'(scrub_wecc), 32'(m_we));
    chk("sec_cnt", 32'(sec_cnt), m_sec);
    chk("ded_cnt", 32'(ded_cnt), m_ded);
    chk("last_err_addr", 32'(last_err_addr), m_last);
    chk("ded_pulse", 32'(ded_pulse), 32'(m_dp));
    chk("pass_done", 32'(pass_done), 32'(m_pd));
  endtask

  // Called at a falling edge: drive, record transfers, clock, then compare.
  task automatic step(input bit en, input bit gnt, input bit sng, input bit dbl,
                      input logic [31:0] dout, input logic [6:0] ecc,
                      input bit fv, input int fa);
    wr_t w;
    scrub_en = en; scrub_gnt = gnt; dec_single = sng; dec_double = dbl;
    dec_dout = dout; dec_ecc_out = ecc; func_wr_vld = fv; func_wr_addr = AW'(fa);
    if (scrub_req === 1'b1 && gnt) begin
      if (scrub_wr) begin
        w.addr = int'(scrub_addr); w.data = scrub_wdata; w.ecc = scrub_wecc;
        writes.push_back(w);
      end else begin
        reads.push_back(int'(scrub_addr));
        rd_cyc.push_back(t);
      end
    end
    @(posedge clk);
    model_edge(en, gnt, sng, dbl, dout, ecc, fv, fa);
    @(negedge clk);
    compare_all();
    if (ded_pulse) n_dp++;
    if (pass_done) n_pd++;
    t++;
  endtask

  task automatic auto_step(input bit en, input bit gnt_rr, input bit gnt_wr);
    logic [31:0] dout;
    logic [6:0]  ecc;
    bit          sng, dbl, fv;
    int          fa;
    dout = $urandom; ecc = 7'($urandom); fv = 1'b0; fa = 0;
    if (m_ph == P_RW) begin
      sng = (inj_s == -2) || (inj_s == m_addr);
      dbl = (inj_d == m_addr);
      if (sng && inj_fixed) begin dout = inj_dout; ecc = inj_ecc; end
      if (hz_addr == m_addr) begin fv = 1'b1; fa = hz_addr; end
    end else begin
      sng = 1'($urandom);
      dbl = 1'($urandom);
    end
    step(en, (m_ph == P_WR) ? gnt_wr : gnt_rr, sng, dbl, dout, ecc, fv, fa);
  endtask

  task automatic random_step();
    int r;
    r = $urandom_range(0, 5);
    step($urandom_range(0, 7) != 0, 1'($urandom), r == 0, r == 1, $urandom, 7'($urandom),
         $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1));
  endtask

  task automatic clear_obs();
    writes.delete(); reads.delete(); rd_cyc.delete(); n_dp = 0; n_pd = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int ns0;
    rst_l = 1'b0; scrub_en = 1'b0; scrub_gnt = 1'b0; dec_dout = '0; dec_ecc_out = '0;
    dec_single = 1'b0; dec_double = 1'b0; func_wr_vld = 1'b0; func_wr_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_sec", 32'(sec_cnt), 0);
    chk("rst_addr", 32'(scrub_addr), 0);
    chk("rst_busy", 32'(scrub_busy), 0);
    rst_l = 1'b1;

    // clean pass: reads 0..3 spaced INTERVAL+2 cycles, one pass_done
    clear_obs();
    t0 = t;
    for (int i = 0; i < 26; i++) auto_step(1'b1, 1'b1, 1'b1);
    chk("B_nreads", reads.size(), 4);
    for (int k = 0; k < reads.size() && k < 4; k++) begin
      chk("B_rd_addr", reads[k], k);
      chk("B_rd_time", rd_cyc[k] - t0, 4 + 6 * k);
    end
    chk("B_nwrites", writes.size(), 0);
    chk("B_pass", n_pd, 1);
    chk("B_sec", 32'(sec_cnt), 0);
    chk("B_ded", 32'(ded_cnt), 0);

    // single error at address 2 is written back verbatim
    clear_obs();
    inj_s = 2; inj_fixed = 1'b1; inj_dout = 32'hDEADBEEF; inj_ecc = 7'h15;
    for (int i = 0; i < 60 && writes.size() == 0; i++) auto_step(1'b1, 1'b1, 1'b1);
    inj_s = -1; inj_fixed = 1'b0;
    chk("C_nwrites", writes.size(), 1);
    if (writes.size() > 0) begin
      chk("C_waddr", writes[0].addr, 2);
      chk("C_wdata", writes[0].data, 32'hDEADBEEF);
      chk("C_wecc", 32'(writes[0].ecc), 32'h15);
    end
    chk("C_sec", 32'(sec_cnt), 1);
    chk("C_last", 32'(last_err_addr), 2);

    // double error at address 1: no write, one pulse, next read is 2
    clear_obs();
    inj_d = 1;
    for (int i = 0; i < 60 && n_dp == 0; i++) auto_step(1'b1, 1'b1, 1'b1);
    inj_d = -1;
    reads.delete();
    for (int i = 0; i < 40 && reads.size() == 0; i++) auto_step(1'b1, 1'b1, 1'b1);
    chk("D_nreads", reads.size(), 1);
    if (reads.size() > 0) chk("D_next_rd", reads[0], 2);
    chk("D_nwrites", writes.size(), 0);
    chk("D_pulses", n_dp, 1);
    chk("D_ded", 32'(ded_cnt), 1);
    chk("D_last", 32'(last_err_addr), 1);

    // single at 3, grant withheld 5 cycles with scrub_en dropped
    inj_s = 3;
    for (int i = 0; i < 40 && m_ph != P_WR; i++) auto_step(1'b1, 1'b1, 1'b1);
    inj_s = -1;
    chk("E_in_wr", 32'(scrub_wr), 1);
    writes.delete();
    for (int i = 0; i < 5; i++) begin
      auto_step(1'b0, 1'b1, 1'b0);
      chk("E_hold_req", 32'(scrub_req), 1);
      chk("E_hold_wr", 32'(scrub_wr), 1);
    end
    chk("E_nowrite_yet", writes.size(), 0);
    auto_step(1'b0, 1'b1, 1'b1);
    chk("E_nwrites", writes.size(), 1);
    if (writes.size() > 0) chk("E_waddr", writes[0].addr, 3);
    chk("E_idle", 32'(scrub_busy), 0);

    // functional write hazard on address 0 during RD_WAIT
    clear_obs();
    inj_s = 0; hz_addr = 0;
    for (int i = 0; i < 80 && reads.size() < 2; i++) auto_step(1'b1, 1'b1, 1'b1);
    inj_s = -1; hz_addr = -1;
    chk("F_nwrites", writes.size(), 0);
    chk("F_sec", 32'(sec_cnt), 3);
    chk("F_nreads", reads.size(), 2);
    if (reads.size() > 1) chk("F_next_rd", reads[1], 1);

    for (int i = 0; i < 2500; i++) random_step();

    // saturation from FFFE, then reset while a write is pending
    force dut.sec_cnt = 16'hFFFE;
    #1;
    release dut.sec_cnt;
    m_sec = 16'hFFFE;
    inj_s = -2;
    ns0 = m_nsingle;
    for (int i = 0; i < 200 && m_nsingle - ns0 < 3; i++) auto_step(1'b1, 1'b1, 1'b1);
    chk("H_sec_sat", 32'(sec_cnt), 32'hFFFF);
    for (int i = 0; i < 40 && m_ph != P_WR; i++) auto_step(1'b1, 1'b1, 1'b0);
    chk("H_in_wr", 32'(scrub_wr), 1);
    #1 rst_l = 1'b0;
    #1;
    model_reset();
    chk("H_async_req", 32'(scrub_req), 0);
    chk("H_async_wr", 32'(scrub_wr), 0);
    chk("H_async_sec", 32'(sec_cnt), 0);
    chk("H_async_busy", 32'(scrub_busy), 0);
    chk("H_async_wdata", scrub_wdata, 0);
    writes.delete();
    @(negedge clk);
    compare_all();
    for (int i = 0; i < 3; i++) auto_step(1'b1, 1'b1, 1'b1);
    chk("H_no_write", writes.size(), 0);
    inj_s = -1;
    rst_l = 1'b1;
    for (int i = 0; i < 12; i++) auto_step(1'b1, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
